// File: rtl/macrocell_pkg.sv
// macrocell_pkg
//   Shared types and configuration-vector layout for the programmable
//   macrocell. Field positions are functions of the product-term count so
//   the top level and any software/fuse tooling agree on one layout.
//   Layout (LSB first): pt_include[PT_COUNT-1:0], reg_mode[1:0], xor_invert,
//   ce_select, clr_select, preset_select, expander_share.
package macrocell_pkg;

  typedef enum logic [1:0] {
    BYPASS  = 2'b00,
    DFF     = 2'b01,
    TFF     = 2'b10,
    FAST_IN = 2'b11
  } reg_mode_e;

  function automatic int cfg_width(input int pt_count);
    return pt_count + 7;
  endfunction

  function automatic int reg_mode_lsb(input int pt_count);
    return pt_count;
  endfunction

  function automatic int xor_invert_bit(input int pt_count);
    return pt_count + 2;
  endfunction

  function automatic int ce_select_bit(input int pt_count);
    return pt_count + 3;
  endfunction

  function automatic int clr_select_bit(input int pt_count);
    return pt_count + 4;
  endfunction

  function automatic int preset_select_bit(input int pt_count);
    return pt_count + 5;
  endfunction

  function automatic int expander_share_bit(input int pt_count);
    return pt_count + 6;
  endfunction

endpackage

// File: rtl/parametric_macrocell_if.sv
// parametric_macrocell_if
//   Bundles the macrocell's array-side and neighbour-side signals.
//   master: AND-array / fuse side (drives configuration, product terms,
//           fast input pin and incoming expander chain).
//   slave : the macrocell itself.
//   Signals: configuration, product_term_results, input_from_io_pin,
//   parallel_expander_in/out, expander_product_term_output,
//   macrocell_output, register_feedback.
interface parametric_macrocell_if #(
  parameter int PT_COUNT = 5
);
  localparam int CFG_W = PT_COUNT + 7;

  logic [CFG_W-1:0]    configuration;
  logic [PT_COUNT-1:0] product_term_results;
  logic                input_from_io_pin;
  logic                parallel_expander_in;
  logic                parallel_expander_out;
  logic                expander_product_term_output;
  logic                macrocell_output;
  logic                register_feedback;

  modport master (
    output configuration, product_term_results, input_from_io_pin,
           parallel_expander_in,
    input  parallel_expander_out, expander_product_term_output,
           macrocell_output, register_feedback
  );

  modport slave (
    input  configuration, product_term_results, input_from_io_pin,
           parallel_expander_in,
    output parallel_expander_out, expander_product_term_output,
           macrocell_output, register_feedback
  );
endinterface

// File: rtl/macrocell_register.sv
// macrocell_register
//   Macrocell flip-flop with synchronous clear/preset priority, clock
//   enable and D/T/fast-input mode selection.
//   Ports: i_clk, i_rst (async, active-high), i_mode, i_logic_out,
//   i_fast_in, i_sync_clr, i_sync_pre, i_enable, o_q.
module macrocell_register
  import macrocell_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_rst,
  input  reg_mode_e i_mode,
  input  logic      i_logic_out,
  input  logic      i_fast_in,
  input  logic      i_sync_clr,
  input  logic      i_sync_pre,
  input  logic      i_enable,
  output logic      o_q
);
  logic r_q;

  // Clear beats preset, and both act even when the clock enable is low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= 1'b0;
    end else if (i_sync_clr) begin
      r_q <= 1'b0;
    end else if (i_sync_pre) begin
      r_q <= 1'b1;
    end else if (i_enable) begin
      case (i_mode)
        DFF:     r_q <= i_logic_out;
        TFF:     r_q <= r_q ^ i_logic_out;
        FAST_IN: r_q <= i_fast_in;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/parametric_macrocell.sv
// parametric_macrocell
//   CPLD-style macrocell: product-term selection, sum-of-products with
//   optional parallel expander chain, XOR polarity control, a configurable
//   register (macrocell_register) and the output mux.
//   Ports: global_clock, global_clear (async, active-high), bus (slave
//   modport of parametric_macrocell_if carrying configuration, product
//   terms, fast input, expander chain and the three cell outputs).
//   Build option: MACROCELL_PARALLEL_EXPANDER_EN -- when defined the
//   incoming parallel expander is ORed into the sum and forwarded; when
//   undefined it is ignored and parallel_expander_out is tied to 0.
module parametric_macrocell
  import macrocell_pkg::*;
#(
  parameter int PT_COUNT = 5
) (
  input logic                  global_clock,
  input logic                  global_clear,
  parametric_macrocell_if.slave bus
);
  localparam int CFG_W    = cfg_width(PT_COUNT);
  localparam int MODE_LSB = reg_mode_lsb(PT_COUNT);

  logic [PT_COUNT-1:0] w_pt;
  logic [PT_COUNT-1:0] w_pt_include;
  logic [PT_COUNT-1:0] w_repurposed;
  reg_mode_e           w_mode;
  logic                w_xor_invert;
  logic                w_ce_sel;
  logic                w_clr_sel;
  logic                w_pre_sel;
  logic                w_share;
  logic                w_sum_terms;
  logic                w_sum;
  logic                w_logic_out;
  logic                w_q;
  logic                w_sync_clr;
  logic                w_sync_pre;
  logic                w_enable;

  assign w_pt         = bus.product_term_results;
  assign w_pt_include = bus.configuration[PT_COUNT-1:0];
  assign w_mode       = reg_mode_e'(bus.configuration[MODE_LSB +: 2]);
  assign w_xor_invert = bus.configuration[xor_invert_bit(PT_COUNT)];
  assign w_ce_sel     = bus.configuration[ce_select_bit(PT_COUNT)];
  assign w_clr_sel    = bus.configuration[clr_select_bit(PT_COUNT)];
  assign w_pre_sel    = bus.configuration[preset_select_bit(PT_COUNT)];
  assign w_share      = bus.configuration[expander_share_bit(PT_COUNT)];

  // Terms borrowed for control are pulled out of the sum. With
  // PT_COUNT=3 PT[1] can be both preset and enable, hence the ORs.
  always_comb begin
    w_repurposed               = '0;
    w_repurposed[0]            = w_clr_sel;
    w_repurposed[1]            = w_repurposed[1] | w_pre_sel;
    w_repurposed[PT_COUNT-2]   = w_repurposed[PT_COUNT-2] | w_ce_sel;
    w_repurposed[PT_COUNT-1]   = w_repurposed[PT_COUNT-1] | w_share;
  end

  assign w_sum_terms = |(w_pt & w_pt_include & ~w_repurposed);

`ifdef MACROCELL_PARALLEL_EXPANDER_EN
  assign w_sum                     = w_sum_terms | bus.parallel_expander_in;
  assign bus.parallel_expander_out = w_sum;
`else
  assign w_sum                     = w_sum_terms;
  assign bus.parallel_expander_out = 1'b0;
`endif

  assign w_logic_out = w_sum ^ w_xor_invert;

  assign w_sync_clr = w_clr_sel & w_pt[0];
  assign w_sync_pre = w_pre_sel & w_pt[1];
  assign w_enable   = ~w_ce_sel | w_pt[PT_COUNT-2];

  macrocell_register u_reg (
    .i_clk       (global_clock),
    .i_rst       (global_clear),
    .i_mode      (w_mode),
    .i_logic_out (w_logic_out),
    .i_fast_in   (bus.input_from_io_pin),
    .i_sync_clr  (w_sync_clr),
    .i_sync_pre  (w_sync_pre),
    .i_enable    (w_enable),
    .o_q         (w_q)
  );

  // Shared expander is active-low so an unused one reads as 1.
  assign bus.expander_product_term_output = w_share ? ~w_pt[PT_COUNT-1] : 1'b1;
  assign bus.macrocell_output  = (w_mode == BYPASS) ? w_logic_out : w_q;
  assign bus.register_feedback = w_q;
endmodule

// File: tb/tb_parametric_macrocell.sv
// tb_parametric_macrocell
//   Directed scenarios followed by randomized configuration/product-term
//   traffic, all checked against a behavioural model of the macrocell.
module tb_parametric_macrocell;
  localparam int N  = 5;
  localparam int CW = N + 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  logic mq;                  // model register state

  parametric_macrocell_if #(.PT_COUNT(N)) bus ();

  parametric_macrocell #(.PT_COUNT(N)) dut (
    .global_clock (clk),
    .global_clear (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] mk(input logic [N-1:0] inc, input int mode,
                                       input bit xinv, input bit ce, input bit clr,
                                       input bit pre, input bit share);
    logic [CW-1:0] c;
    logic [31:0]   m;
    m        = mode;
    c        = '0;
    c[N-1:0] = inc;
    c[N]     = m[0];
    c[N+1]   = m[1];
    c[N+2]   = xinv;
    c[N+3]   = ce;
    c[N+4]   = clr;
    c[N+5]   = pre;
    c[N+6]   = share;
    return c;
  endfunction

  function automatic bit m_sum();
    bit s;
    s = 0;
    for (int i = 0; i < N; i++) begin
      bit rp;
      rp = (i == 0 && bus.configuration[N+4]) || (i == 1 && bus.configuration[N+5]) ||
           (i == N-2 && bus.configuration[N+3]) || (i == N-1 && bus.configuration[N+6]);
      if (bus.configuration[i] && bus.product_term_results[i] && !rp) s = 1;
    end
`ifdef MACROCELL_PARALLEL_EXPANDER_EN
    if (bus.parallel_expander_in) s = 1;
`endif
    return s;
  endfunction

  function automatic bit m_lo();
    return m_sum() ^ bus.configuration[N+2];
  endfunction

  function automatic int m_mode();
    return 2 * int'(bus.configuration[N+1]) + int'(bus.configuration[N]);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    bit pexp;
`ifdef MACROCELL_PARALLEL_EXPANDER_EN
    pexp = m_sum();
`else
    pexp = 0;
`endif
    chk({tag, ".out"}, bus.macrocell_output, (m_mode() == 0) ? m_lo() : mq);
    chk({tag, ".fb"},  bus.register_feedback, mq);
    chk({tag, ".exp"}, bus.expander_product_term_output,
        bus.configuration[N+6] ? ~bus.product_term_results[N-1] : 1'b1);
    chk({tag, ".pex"}, bus.parallel_expander_out, pexp);
  endtask

  task automatic tick();
    logic nq;
    if (rst)                                                         nq = 0;
    else if (bus.configuration[N+4] && bus.product_term_results[0])  nq = 0;
    else if (bus.configuration[N+5] && bus.product_term_results[1])  nq = 1;
    else if (bus.configuration[N+3] && !bus.product_term_results[N-2]) nq = mq;
    else begin
      case (m_mode())
        1:       nq = m_lo();
        2:       nq = mq ^ m_lo();
        3:       nq = bus.input_from_io_pin;
        default: nq = mq;
      endcase
    end
    @(posedge clk);
    #1;
    mq = nq;
  endtask

  task automatic drive(input logic [CW-1:0] cfg, input logic [N-1:0] pt,
                       input logic io, input logic pin);
    bus.configuration        = cfg;
    bus.product_term_results = pt;
    bus.input_from_io_pin    = io;
    bus.parallel_expander_in = pin;
  endtask

  initial begin
    logic [3:0] tseq;
    mq = 0;
    drive(mk(5'b00001, 1, 0, 0, 0, 0, 0), 5'b00000, 0, 0);
    #2;
    chk_all("reset");
    // preset requested while global_clear is held must not set q
    drive(mk(5'b00000, 1, 0, 0, 0, 1, 0), 5'b00010, 0, 0);
    tick();
    chk("reset_over_preset", bus.register_feedback, 1'b0);
    chk_all("reset_hold");
    #2 rst = 0;

    // D mode, single included term
    drive(mk(5'b00001, 1, 0, 0, 0, 0, 0), 5'b00001, 0, 0);
    #1;
    chk("d_pre_edge", bus.macrocell_output, 1'b0);
    tick();
    chk("d_post_edge", bus.macrocell_output, 1'b1);
    chk_all("d_mode");

    // T mode toggling from q=0
    drive(mk(5'b00001, 1, 0, 0, 0, 0, 0), 5'b00000, 0, 0);
    tick();
    chk("t_init", bus.register_feedback, 1'b0);
    drive(mk(5'b00001, 2, 0, 0, 0, 0, 0), 5'b00001, 0, 0);
    tseq = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t_seq", bus.register_feedback, tseq[k]);
      chk_all("t_mode");
    end

    // simultaneous sync clear and preset: clear wins
    drive(mk(5'b00100, 1, 0, 0, 1, 1, 0), 5'b00011, 0, 0);
    tick();
    chk("clr_wins", bus.register_feedback, 1'b0);
    drive(mk(5'b00100, 1, 0, 0, 1, 1, 0), 5'b00010, 0, 0);
    tick();
    chk("preset", bus.register_feedback, 1'b1);
    chk_all("clr_pre");

    // clock enable low holds q while D input toggles
    for (int k = 0; k < 3; k++) begin
      drive(mk(5'b00001, 1, 0, 1, 0, 0, 0), (k % 2 == 0) ? 5'b00000 : 5'b00001, 0, 0);
      tick();
      chk("ce_hold", bus.register_feedback, 1'b1);
      chk_all("ce_low");
    end
    drive(mk(5'b00001, 1, 0, 1, 0, 0, 0), 5'b01000, 0, 0);
    tick();
    chk("ce_follow", bus.register_feedback, 1'b0);
    chk_all("ce_high");

    // async clear mid-cycle, bypass output keeps tracking during reset
    drive(mk(5'b00001, 1, 0, 0, 0, 0, 0), 5'b00001, 0, 0);
    tick();
    chk("pre_clear_q", bus.register_feedback, 1'b1);
    #2 rst = 1;
    #1 mq = 0;
    chk("async_clear", bus.register_feedback, 1'b0);
    drive(mk(5'b00001, 0, 0, 0, 0, 0, 0), 5'b00001, 0, 0);
    #1;
    chk("rst_bypass_hi", bus.macrocell_output, 1'b1);
    chk_all("rst_bypass1");
    drive(mk(5'b00001, 0, 0, 0, 0, 0, 0), 5'b00000, 0, 0);
    #1;
    chk("rst_bypass_lo", bus.macrocell_output, 1'b0);
    chk_all("rst_bypass0");
    rst = 0;

    // configuration change mid-cycle does not disturb q
    drive(mk(5'b00001, 1, 0, 0, 0, 0, 0), 5'b00001, 0, 0);
    tick();
    #2;
    drive(mk(5'b00001, 0, 0, 0, 0, 0, 0), 5'b00000, 0, 0);
    #1;
    chk("cfg_change_q", bus.register_feedback, 1'b1);
    chk_all("cfg_change");
    tick();
    chk("bypass_holds", bus.register_feedback, 1'b1);
    drive(mk(5'b00001, 3, 0, 0, 0, 0, 0), 5'b00000, 0, 0);
    tick();
    chk("fast_in0", bus.register_feedback, 1'b0);
    drive(mk(5'b00001, 3, 0, 0, 0, 0, 0), 5'b00000, 1, 0);
    tick();
    chk("fast_in1", bus.register_feedback, 1'b1);

    // parallel expander with inverted polarity, all PTs low
    drive(mk(5'b11111, 0, 1, 0, 0, 0, 0), 5'b00000, 0, 1);
    #1;
`ifdef MACROCELL_PARALLEL_EXPANDER_EN
    chk("pexp_out", bus.macrocell_output, 1'b0);
    chk("pexp_chain", bus.parallel_expander_out, 1'b1);
`else
    chk("pexp_out", bus.macrocell_output, 1'b1);
    chk("pexp_chain", bus.parallel_expander_out, 1'b0);
`endif
    chk_all("pexp");

    // shared expander term
    drive(mk(5'b11111, 0, 0, 0, 0, 0, 1), 5'b10000, 0, 0);
    #1;
    chk("share_lo", bus.expander_product_term_output, 1'b0);
    chk("share_excluded", bus.macrocell_output, 1'b0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(CW'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
      #1;
      chk_all("rnd_pre");
      tick();
      chk_all("rnd_post");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
